ascon_aead128_axi_slave: RTL and testbench



---
 rtl/ascon_aead128_pkg.sv | 44 ++++
 rtl/ascon_aead128_axi_wr_ch.sv | 89 ++++++++
 rtl/ascon_aead128_axi_slave.sv | 182 ++++++++++++++++++
 tb/tb_ascon_aead128_axi_slave.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_aead128_pkg.sv
// Shared register map, response codes and small helpers for the Ascon-AEAD128 AXI front-end.
package ascon_aead128_pkg;

    localparam int unsigned NB_REGS = 26;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned STATUS_READY      = 0;
    localparam int unsigned STATUS_AEAD_END   = 1;
    localparam int unsigned STATUS_DOUT_VALID = 2;

    typedef enum logic [4:0] {
        RegControl = 5'd0,
        RegStatus  = 5'd1,
        RegKey0    = 5'd2,
        RegNonce0  = 5'd6,
        RegAd0     = 5'd10,
        RegAd3     = 5'd13,
        RegDin0    = 5'd14,
        RegDin3    = 5'd17,
        RegDout0   = 5'd18,
        RegTag0    = 5'd22
    } reg_idx_e;

    function automatic logic [6:0] index_to_byte_offset(input logic [4:0] idx);
        return {idx, 2'b00};
    endfunction

    function automatic logic in_block(input logic [4:0] idx, input logic [4:0] base);
        return (idx >= base) && (idx <= base + 5'd3);
    endfunction

    // Replace the masked bits of 32-bit word 'sel' inside a 128-bit operand.
    function automatic logic [127:0] merge_word(input logic [127:0] old, input logic [1:0] sel,
                                                input logic [31:0] data, input logic [31:0] mask);
        logic [127:0] m;
        logic [127:0] d;
        m = {96'b0, mask} << {sel, 5'b0};
        d = {96'b0, data & mask} << {sel, 5'b0};
        return (old & ~m) | d;
    endfunction

endpackage

// File: rtl/ascon_aead128_axi_wr_ch.sv
// AXI4-Lite write channel: independent AW/W holders, single outstanding B response,
// and byte-strobe to bit-mask expansion for the register file.
module ascon_aead128_axi_wr_ch
    import ascon_aead128_pkg::*;
#(
    parameter int unsigned IDX_W = 5
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [IDX_W-1:0] aw_idx_i,
    input  logic             awvalid_i,
    output logic             awready_o,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    output logic [1:0]       bresp_o,
    output logic             bvalid_o,
    input  logic             bready_i,
    input  logic             wr_slverr_i,
    output logic             wr_en_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic [31:0]      wr_data_o,
    output logic [31:0]      wr_mask_o
);

    logic             init_q;
    logic             aw_full_q;
    logic             w_full_q;
    logic             bvalid_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic [1:0]       bresp_q;
    logic             b_done;

    // init_q keeps the readies low while reset is asserted.
    assign awready_o = init_q && !aw_full_q;
    assign wready_o  = init_q && !w_full_q;
    assign wr_en_o   = aw_full_q && w_full_q && !bvalid_q;
    assign b_done    = bvalid_q && bready_i;

    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign wr_idx_o  = aw_idx_q;
    assign wr_data_o = w_data_q;

    always_comb begin
        wr_mask_o = '0;
        for (int b = 0; b < 4; b++) begin
            wr_mask_o[8*b +: 8] = {8{w_strb_q[b]}};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_q    <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            init_q <= 1'b1;
            if (awvalid_i && awready_o) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= aw_idx_i;
            end else if (b_done) begin
                aw_full_q <= 1'b0;
            end
            if (wvalid_i && wready_o) begin
                w_full_q <= 1'b1;
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end else if (b_done) begin
                w_full_q <= 1'b0;
            end
            if (wr_en_o) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_slverr_i ? RESP_SLVERR : RESP_OKAY;
            end else if (b_done) begin
                bvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ascon_aead128_axi_slave.sv
// AXI4-Lite register front-end for the Ascon-AEAD128 core: operand/control registers,
// output capture registers, sticky status and an inline read path.
module ascon_aead128_axi_slave
    import ascon_aead128_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [127:0]          key_o,
    output logic [127:0]          nonce_o,
    output logic                  start_o,
    output logic                  mode_o,
    output logic [127:0]          ad_o,
    output logic                  ad_valid_o,
    output logic [127:0]          din_o,
    output logic                  din_valid_o,
    input  logic                  core_ready_i,
    input  logic [127:0]          dout_i,
    input  logic                  dout_valid_i,
    input  logic [127:0]          tag_i,
    input  logic                  tag_valid_i
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REGS - 1);

    logic [31:0]  control_q;
    logic [127:0] key_q, nonce_q, ad_q, din_q, dout_q, tag_q;
    logic         aead_end_q, dout_valid_q, ad_valid_q, din_valid_q;
    logic         init_q, rvalid_q;
    logic [31:0]  rdata_q;
    logic [1:0]   rresp_q;

    logic             wr_en, wr_writable, wr_apply, start_clr, din_clr;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data, wr_mask, status, rd_data;
    logic [1:0]       wr_sel, rd_sel, rd_resp;
    logic [IDX_W-1:0] rd_idx;
    logic             unused_sig;

    assign unused_sig = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    ascon_aead128_axi_wr_ch #(
        .IDX_W(IDX_W)
    ) u_wr_ch (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .aw_idx_i   (awaddr[ADDR_WIDTH-1:2]),
        .awvalid_i  (awvalid),
        .awready_o  (awready),
        .wdata_i    (wdata),
        .wstrb_i    (wstrb),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .bresp_o    (bresp),
        .bvalid_o   (bvalid),
        .bready_i   (bready),
        .wr_slverr_i(!wr_writable),
        .wr_en_o    (wr_en),
        .wr_idx_o   (wr_idx),
        .wr_data_o  (wr_data),
        .wr_mask_o  (wr_mask)
    );

    assign wr_writable = (wr_idx == RegControl) || in_block(wr_idx, RegKey0) ||
                         in_block(wr_idx, RegNonce0) || in_block(wr_idx, RegAd0) ||
                         in_block(wr_idx, RegDin0);
    assign wr_apply  = wr_en && wr_writable && (|wr_mask);
    // Operand blocks start at indices 2 mod 4, so word-in-block is idx[1:0] - 2.
    assign wr_sel    = wr_idx[1:0] - 2'd2;
    assign rd_sel    = rd_idx[1:0] - 2'd2;
    assign start_clr = wr_apply && (wr_idx == RegControl) && wr_mask[0] && wr_data[0];
    assign din_clr   = wr_apply && (wr_idx == RegDin3);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            control_q    <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            ad_q         <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            tag_q        <= '0;
            aead_end_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            ad_valid_q   <= 1'b0;
            din_valid_q  <= 1'b0;
        end else begin
            if (wr_apply) begin
                if (wr_idx == RegControl) control_q <= (control_q & ~wr_mask) | (wr_data & wr_mask);
                if (in_block(wr_idx, RegKey0))   key_q   <= merge_word(key_q, wr_sel, wr_data, wr_mask);
                if (in_block(wr_idx, RegNonce0)) nonce_q <= merge_word(nonce_q, wr_sel, wr_data, wr_mask);
                if (in_block(wr_idx, RegAd0))    ad_q    <= merge_word(ad_q, wr_sel, wr_data, wr_mask);
                if (in_block(wr_idx, RegDin0))   din_q   <= merge_word(din_q, wr_sel, wr_data, wr_mask);
            end
            ad_valid_q  <= wr_apply && (wr_idx == RegAd3);
            din_valid_q <= din_clr;
            if (dout_valid_i) dout_q <= dout_i;
            if (tag_valid_i)  tag_q  <= tag_i;
            // Set events take priority over clears landing in the same cycle.
            if (tag_valid_i)    aead_end_q <= 1'b1;
            else if (start_clr) aead_end_q <= 1'b0;
            if (dout_valid_i)              dout_valid_q <= 1'b1;
            else if (start_clr || din_clr) dout_valid_q <= 1'b0;
        end
    end

    always_comb begin
        status                    = '0;
        status[STATUS_READY]      = core_ready_i && !ad_valid_q && !din_valid_q;
        status[STATUS_AEAD_END]   = aead_end_q;
        status[STATUS_DOUT_VALID] = dout_valid_q;
    end

    assign rd_idx = araddr[ADDR_WIDTH-1:2];

    // KEY words fall through to zero: the key is write-only.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (rd_idx > LAST_IDX)                rd_resp = RESP_SLVERR;
        else if (rd_idx == RegControl)        rd_data = control_q;
        else if (rd_idx == RegStatus)         rd_data = status;
        else if (in_block(rd_idx, RegNonce0)) rd_data = nonce_q[{rd_sel, 5'b0} +: 32];
        else if (in_block(rd_idx, RegAd0))    rd_data = ad_q[{rd_sel, 5'b0} +: 32];
        else if (in_block(rd_idx, RegDin0))   rd_data = din_q[{rd_sel, 5'b0} +: 32];
        else if (in_block(rd_idx, RegDout0))  rd_data = dout_q[{rd_sel, 5'b0} +: 32];
        else if (in_block(rd_idx, RegTag0))   rd_data = tag_q[{rd_sel, 5'b0} +: 32];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            init_q <= 1'b1;
            if (arvalid && arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign arready     = init_q && !rvalid_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign key_o       = key_q;
    assign nonce_o     = nonce_q;
    assign start_o     = control_q[0];
    assign mode_o      = control_q[1];
    assign ad_o        = ad_q;
    assign ad_valid_o  = ad_valid_q;
    assign din_o       = din_q;
    assign din_valid_o = din_valid_q;

endmodule

// File: tb/tb_ascon_aead128_axi_slave.sv
// Directed bench for the Ascon-AEAD128 AXI4-Lite front-end with hand-computed expectations.
module tb_ascon_aead128_axi_slave;
    import ascon_aead128_pkg::*;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [6:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] key_o, nonce_o, ad_o, din_o, dout_i, tag_i;
    logic         start_o, mode_o, ad_valid_o, din_valid_o;
    logic         core_ready_i, dout_valid_i, tag_valid_i;

    int n_vec = 0;
    int n_err = 0;
    int din_pulses = 0;
    int ad_pulses = 0;
    int b_beats = 0;

    always #5 aclk = ~aclk;

    ascon_aead128_axi_slave #(
        .ADDR_WIDTH(7)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awaddr      (awaddr),
        .awprot      (awprot),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .araddr      (araddr),
        .arprot      (arprot),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .key_o       (key_o),
        .nonce_o     (nonce_o),
        .start_o     (start_o),
        .mode_o      (mode_o),
        .ad_o        (ad_o),
        .ad_valid_o  (ad_valid_o),
        .din_o       (din_o),
        .din_valid_o (din_valid_o),
        .core_ready_i(core_ready_i),
        .dout_i      (dout_i),
        .dout_valid_i(dout_valid_i),
        .tag_i       (tag_i),
        .tag_valid_i (tag_valid_i)
    );

    always @(negedge aclk) begin
        if (din_valid_o) din_pulses++;
        if (ad_valid_o) ad_pulses++;
        if (bvalid && bready) b_beats++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit aw_hs, w_hs;
        int cyc;
        aw_hs = 0;
        w_hs  = 0;
        cyc   = 0;
        resp  = 2'bxx;
        @(negedge aclk);
        awaddr  = index_to_byte_offset(5'(idx));
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        while (!(aw_hs && w_hs) && cyc < 20) begin
            if (awvalid && awready) aw_hs = 1;
            if (wvalid && wready) w_hs = 1;
            @(posedge aclk);
            #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        cyc     = 0;
        while (!bvalid && cyc < 20) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        if (bvalid) resp = bresp;
        else check_eq("b_timeout", 0, 1);
        @(posedge aclk);
        #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        data = 'x;
        resp = 2'bxx;
        cyc  = 0;
        @(negedge aclk);
        araddr  = index_to_byte_offset(5'(idx));
        arvalid = 1'b1;
        while (!arready && cyc < 20) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        cyc     = 0;
        while (!rvalid && cyc < 20) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        if (rvalid) begin
            data = rdata;
            resp = rresp;
        end else begin
            check_eq("r_timeout", 0, 1);
        end
        @(posedge aclk);
        #1;
        rready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          p0, b0;

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        core_ready_i = 1'b1; dout_i = '0; dout_valid_i = 0; tag_i = '0; tag_valid_i = 0;

        repeat (2) @(posedge aclk);
        #1;
        check_eq("rst_awready", awready, 0);
        check_eq("rst_wready", wready, 0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_key", key_o, 0);
        check_eq("rst_rdata", rdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check_eq("post_rst_ready", {awready, wready, arready}, 3'b111);

        // KEY load and write-only readback.
        axi_write(2, 32'h03020100, 4'hF, resp); check_eq("key0_bresp", resp, RESP_OKAY);
        axi_write(3, 32'h07060504, 4'hF, resp); check_eq("key1_bresp", resp, RESP_OKAY);
        axi_write(4, 32'h0B0A0908, 4'hF, resp); check_eq("key2_bresp", resp, RESP_OKAY);
        axi_write(5, 32'h0F0E0D0C, 4'hF, resp); check_eq("key3_bresp", resp, RESP_OKAY);
        check_eq("key_o", key_o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        axi_read(3, rd, resp);
        check_eq("key1_rdata", rd, 0);
        check_eq("key1_rresp", resp, RESP_OKAY);

        // DIN3 with W leading AW by several cycles and a stalled B channel.
        axi_write(14, 32'h00000001, 4'hF, resp);
        axi_write(15, 32'h00000002, 4'hF, resp);
        axi_write(16, 32'h00000003, 4'hF, resp);
        p0 = din_pulses;
        b0 = b_beats;
        @(negedge aclk);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk);
        #1;
        wvalid = 1'b0;
        check_eq("w_held_wready", wready, 0);
        repeat (3) @(posedge aclk);
        #1;
        check_eq("aw_idle_awready", awready, 1);
        awaddr = index_to_byte_offset(5'd17); awvalid = 1'b1;
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        repeat (5) begin
            @(posedge aclk);
            #1;
        end
        check_eq("stall_bvalid", bvalid, 1);
        check_eq("stall_awready", awready, 0);
        check_eq("stall_bresp", bresp, RESP_OKAY);
        bready = 1'b1;
        @(posedge aclk);
        #1;
        bready = 1'b0;
        check_eq("b_released", bvalid, 0);
        check_eq("din_pulse_count", din_pulses - p0, 1);
        check_eq("b_beat_count", b_beats - b0, 1);
        check_eq("din_o", din_o, 128'hDEADBEEF_00000003_00000002_00000001);

        // AD byte-strobed update of word 3.
        axi_write(10, 32'h55667788, 4'hF, resp);
        axi_write(13, 32'h11223344, 4'hF, resp);
        p0 = ad_pulses;
        axi_write(13, 32'hAABBCCDD, 4'b0010, resp);
        check_eq("ad3_strb_bresp", resp, RESP_OKAY);
        check_eq("ad3_word", ad_o[127:96], 32'h1122CC44);
        check_eq("ad0_word", ad_o[31:0], 32'h55667788);
        check_eq("ad_pulse_count", ad_pulses - p0, 1);
        axi_read(13, rd, resp);
        check_eq("ad3_readback", rd, 32'h1122CC44);

        // Tag capture, sticky status and clear through CONTROL.
        @(negedge aclk);
        tag_i = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321; tag_valid_i = 1'b1;
        @(negedge aclk);
        tag_valid_i = 1'b0;
        axi_read(1, rd, resp);
        check_eq("status_tag", rd, 32'h3);
        axi_read(22, rd, resp);
        check_eq("tag0", rd, 32'h87654321);
        axi_read(25, rd, resp);
        check_eq("tag3", rd, 32'h12345678);
        axi_write(0, 32'h3, 4'hF, resp);
        check_eq("control_bresp", resp, RESP_OKAY);
        check_eq("start_mode", {start_o, mode_o}, 2'b11);
        axi_read(1, rd, resp);
        check_eq("status_cleared", rd, 32'h1);

        // DOUT capture; a DIN3 write clears dout_valid.
        @(negedge aclk);
        dout_i = 128'h00112233_44556677_8899AABB_CCDDEEFF; dout_valid_i = 1'b1;
        @(negedge aclk);
        dout_valid_i = 1'b0;
        axi_read(1, rd, resp);
        check_eq("status_dout", rd, 32'h5);
        axi_read(19, rd, resp);
        check_eq("dout1", rd, 32'h8899AABB);
        axi_write(17, 32'h0, 4'hF, resp);
        axi_read(1, rd, resp);
        check_eq("status_din_clr", rd, 32'h1);

        // Error responses and no-effect writes.
        axi_write(1, 32'hFFFFFFFF, 4'hF, resp);
        check_eq("status_wr_bresp", resp, RESP_SLVERR);
        axi_read(31, rd, resp);
        check_eq("oob_rresp", resp, RESP_SLVERR);
        check_eq("oob_rdata", rd, 0);
        axi_write(22, 32'hFFFFFFFF, 4'hF, resp);
        check_eq("tag_wr_bresp", resp, RESP_SLVERR);
        axi_read(22, rd, resp);
        check_eq("tag0_unchanged", rd, 32'h87654321);
        axi_write(26, 32'hFFFFFFFF, 4'hF, resp);
        check_eq("idx26_bresp", resp, RESP_SLVERR);
        axi_write(6, 32'hCAFEF00D, 4'hF, resp);
        axi_write(6, 32'hFFFFFFFF, 4'h0, resp);
        check_eq("strb0_bresp", resp, RESP_OKAY);
        axi_read(6, rd, resp);
        check_eq("nonce0_kept", rd, 32'hCAFEF00D);
        check_eq("nonce_o", nonce_o, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D);
        axi_read(0, rd, resp);
        check_eq("control_rd", rd, 32'h3);
        check_eq("status_rd_after_err", {start_o, mode_o}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
